// File: rtl/pe_pkg.sv
// Shared definitions for the PE row: mode bus encoding and the row sequencer state type.
package pe_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAVE   = 2'd1;
    localparam logic [1:0] MODE_SA     = 2'd2;
    localparam logic [1:0] MODE_INIT   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSave,
        StStream,
        StDrain,
        StDone
    } seq_state_e;

    function automatic logic [1:0] seq_mode(input seq_state_e st);
        logic [1:0] mode;
        case (st)
            StSave:            mode = MODE_SAVE;
            StStream, StDrain: mode = MODE_SA;
            default:           mode = MODE_INIT;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/pe_row_sequencer_if.sv
// Handshake, control and PE-facing signals of the row sequencer.
interface pe_row_sequencer_if #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned CNT_W  = 8
);
    logic                  start;
    logic [CNT_W-1:0]      vec_count;
    logic                  w_valid;
    logic [7:0]            w_data;
    logic                  w_ready;
    logic                  x_valid;
    logic [7:0]            x_data;
    logic                  x_ready;
    logic [1:0]            mode_o;
    logic [8*NUM_PE-1:0]   filter_o;
    logic [7:0]            pe_in_o;
    logic                  activate_o;
    logic                  busy;
    logic                  done;

    modport master (
        output start, vec_count, w_valid, w_data, x_valid, x_data,
        input  w_ready, x_ready, mode_o, filter_o, pe_in_o, activate_o, busy, done
    );

    modport slave (
        input  start, vec_count, w_valid, w_data, x_valid, x_data,
        output w_ready, x_ready, mode_o, filter_o, pe_in_o, activate_o, busy, done
    );

endinterface

// File: rtl/pe_row_sequencer.sv
// Loads one weight per PE, commits them with a save pulse, streams activations into PE 0,
// flushes the chain and pulses done. Every output is a register.
module pe_row_sequencer
    import pe_pkg::*;
#(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned CNT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    pe_row_sequencer_if.slave bus
);

    localparam int unsigned          IDX_W    = $clog2(NUM_PE + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PE - 1);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    w_idx_q, w_idx_d;
    logic [IDX_W-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0]    x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]    vec_q, vec_d;
    logic [7:0]          weights_q [NUM_PE];

    logic [1:0]          mode_q, mode_d;
    logic [8*NUM_PE-1:0] filter_q, filter_d;
    logic [7:0]          pe_in_q, pe_in_d;
    logic                activate_q, activate_d;
    logic                w_ready_q, w_ready_d;
    logic                x_ready_q, x_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_fire, x_fire;

    // Ready flags are only ever high in their own state, so the fires need no state qualifier.
    assign w_fire = bus.w_valid && w_ready_q;
    assign x_fire = bus.x_valid && x_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            w_idx_q <= '0;
            drain_q <= '0;
            x_cnt_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            w_idx_q <= w_idx_d;
            drain_q <= drain_d;
            x_cnt_q <= x_cnt_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_idx_d = w_idx_q;
        drain_d = drain_q;
        x_cnt_d = x_cnt_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                w_idx_d = '0;
                drain_d = '0;
                x_cnt_d = '0;
                if (bus.start) begin
                    vec_d   = bus.vec_count;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (w_fire) begin
                    w_idx_d = w_idx_q + 1'b1;
                    if (w_idx_q == LAST_IDX) state_d = StSave;
                end
            end
            StSave:   state_d = (vec_q == '0) ? StDrain : StStream;
            StStream: begin
                if (x_fire) begin
                    x_cnt_d = x_cnt_q + 1'b1;
                end else if (x_cnt_q == vec_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_q == LAST_IDX) state_d = StDone;
                else                     drain_d = drain_q + 1'b1;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        mode_d     = seq_mode(state_d);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
        w_ready_d  = (state_d == StLoad);
        x_ready_d  = (state_d == StStream) && (x_cnt_d < vec_q);
        activate_d = x_fire;
        pe_in_d    = x_fire ? bus.x_data : pe_in_q;
        filter_d   = '0;
        if (state_d == StSave) begin
            for (int k = 0; k < int'(NUM_PE); k++) begin
                filter_d[8*k +: 8] = (w_fire && w_idx_q == IDX_W'(k)) ? bus.w_data : weights_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_PE); k++) weights_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_PE); k++) begin
                if (w_fire && w_idx_q == IDX_W'(k)) weights_q[k] <= bus.w_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_INIT;
            filter_q   <= '0;
            pe_in_q    <= '0;
            activate_q <= 1'b0;
            w_ready_q  <= 1'b0;
            x_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            filter_q   <= filter_d;
            pe_in_q    <= pe_in_d;
            activate_q <= activate_d;
            w_ready_q  <= w_ready_d;
            x_ready_q  <= x_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mode_o     = mode_q;
    assign bus.filter_o   = filter_q;
    assign bus.pe_in_o    = pe_in_q;
    assign bus.activate_o = activate_q;
    assign bus.w_ready    = w_ready_q;
    assign bus.x_ready    = x_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
